// File: rtl/gelu_stream_arbiter.sv
// gelu_stream_arbiter: round-robin shares one gelu_top between NUM_REQ AXI-stream requesters and routes results back by tag.
// Latency: one idle arbitration cycle per packet, then zero-latency forwarding; the return path is purely combinational.
// Backpressure: m_tready feeds only the granted lane; the tag-FIFO head's r_tready drives g_tready; a full tag FIFO stalls arbitration.
module gelu_stream_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int D_W_ACC   = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // requester input streams
    input  logic [NUM_REQ*D_W_ACC-1:0]   s_tdata,
    input  logic [NUM_REQ-1:0]           s_tlast,
    input  logic [NUM_REQ-1:0]           s_tvalid,
    output logic [NUM_REQ-1:0]           s_tready,
    // towards gelu_top qin
    output logic [D_W_ACC-1:0]           m_tdata,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    // from gelu_top qout
    input  logic [D_W_ACC-1:0]           g_tdata,
    input  logic                         g_tlast,
    input  logic                         g_tvalid,
    output logic                         g_tready,
    // per-requester return streams, data/last shared by all lanes
    output logic [D_W_ACC-1:0]           r_tdata,
    output logic                         r_tlast,
    output logic [NUM_REQ-1:0]           r_tvalid,
    input  logic [NUM_REQ-1:0]           r_tready,
    // status
    output logic [$clog2(NUM_REQ)-1:0]   grant,
    output logic                         busy
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int GW1 = GW + 1;
    localparam int PW  = $clog2(TAG_DEPTH);
    localparam int CW  = $clog2(TAG_DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;

    // round-robin search
    logic [GW-1:0]   rr_start;
    logic [GW1-1:0]  cand_w;
    logic [GW-1:0]   cand;
    logic            sel_found;
    logic [GW-1:0]   sel_idx;

    // granted lane view
    logic [D_W_ACC-1:0] lane_dat;
    logic               lane_last;
    logic               lane_vld;

    // tag FIFO: one entry per packet currently inside gelu_top, holding its owner
    logic [GW-1:0]   tag_mem_q [TAG_DEPTH];
    logic [PW-1:0]   tag_wr_q, tag_wr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
    logic            tag_push;
    logic            tag_pop;
    logic            tag_full;
    logic            tag_empty;
    logic [GW-1:0]   tag_head;

    assign tag_full  = (tag_cnt_q == CW'(TAG_DEPTH));
    assign tag_empty = (tag_cnt_q == '0);
    assign tag_head  = tag_mem_q[tag_rd_q];

    // pick the first valid lane after the previous owner, wrapping at NUM_REQ
    always_comb begin
        rr_start  = (last_grant_q == GW'(NUM_REQ - 1)) ? '0 : last_grant_q + GW'(1);
        cand_w    = '0;
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_w = {1'b0, rr_start} + GW1'(k);
            if (cand_w >= GW1'(NUM_REQ)) begin
                cand_w = cand_w - GW1'(NUM_REQ);
            end
            cand = cand_w[GW-1:0];
            if (!sel_found && s_tvalid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // mux the currently granted lane onto a single view
    always_comb begin
        lane_dat  = '0;
        lane_last = 1'b0;
        lane_vld  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                lane_dat  = s_tdata[i*D_W_ACC +: D_W_ACC];
                lane_last = s_tlast[i];
                lane_vld  = s_tvalid[i];
            end
        end
    end

    // arbiter FSM next state and forward-path outputs; grant only moves in IDLE so a packet is never split
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tag_push     = 1'b0;
        m_tdata      = lane_dat;
        m_tlast      = lane_last;
        m_tvalid     = 1'b0;
        s_tready     = '0;

        case (state_q)
            IDLE: begin
                // arbitration cycle: nothing is forwarded here
                if (sel_found && !tag_full) begin
                    grant_d  = sel_idx;
                    tag_push = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!rst) begin
                    m_tvalid = lane_vld;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        s_tready[i] = (grant_q == GW'(i)) && m_tready;
                    end
                end
                if (lane_vld && m_tready && lane_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // arbiter state registers; reset makes lane 0 the first winner
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // return routing: the oldest outstanding tag owns gelu_top's output; with no tag, nothing is accepted
    always_comb begin
        r_tvalid = '0;
        g_tready = 1'b0;
        if (!tag_empty && !rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tag_head == GW'(i)) begin
                    r_tvalid[i] = g_tvalid;
                    g_tready    = r_tready[i];
                end
            end
        end
        tag_pop = g_tvalid && g_tready && g_tlast;
    end

    assign r_tdata = g_tdata;
    assign r_tlast = g_tlast;

    // tag FIFO pointer/occupancy next state; depth is a power of two so pointers wrap on their own
    always_comb begin
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        tag_cnt_d = tag_cnt_q;
        if (tag_push) begin
            tag_wr_d = tag_wr_q + PW'(1);
        end
        if (tag_pop) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end
        case ({tag_push, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    // tag FIFO pointers and count; reset empties it and abandons anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
        end else begin
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_cnt_q <= tag_cnt_d;
        end
    end

    // tag FIFO storage; contents are only meaningful below the count so no reset is needed
    always_ff @(posedge clk) begin
        if (tag_push && !rst) begin
            tag_mem_q[tag_wr_q] <= grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY) && !rst;

endmodule
